demux_1tom_buf: RTL and testbench

- Parametrised 1-to-M valid/ready demultiplexer with a small per-destination FIFO.
- Routes each source beat to the destination chosen by a binary select.
- Decouples destinations: a stalled destination blocks only beats addressed to it. Payload lines of idle outputs are held at zero.
- Sits between a single producer and M crossbar/arbiter inputs; successor of the combinational 1-to-2 mux.

---
 rtl/demux_1tom_buf_pkg.sv | 20 ++
 rtl/demux_1tom_buf_if.sv | 31 +++
 rtl/sync_fifo_vr.sv | 57 +++++
 rtl/demux_1tom_buf.sv | 69 ++++++
 tb/tb_demux_1tom_buf.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/demux_1tom_buf_pkg.sv
// rtl/demux_1tom_buf_pkg.sv - shared constants and helpers for the 1-to-M buffered demux
package demux_1tom_buf_pkg;

  localparam int M_DEF     = 4;
  localparam int W_DEF     = 8;
  localparam int DEPTH_DEF = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Low bit of entry idx in a packed bus of width-bit entries
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/demux_1tom_buf_if.sv
// rtl/demux_1tom_buf_if.sv - source/destination bundle of the 1-to-M buffered demux
interface demux_1tom_buf_if
  import demux_1tom_buf_pkg::*;
#(
  parameter int M     = M_DEF,
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) ();
  localparam int SW = clog2(M);
  localparam int CW = clog2(DEPTH + 1);

  logic            vld_src;
  logic [W-1:0]    pld_src;
  logic [SW-1:0]   sel_src;
  logic            rdy_src;
  logic [M-1:0]    vld_dst;
  logic [M*W-1:0]  pld_dst;
  logic [M-1:0]    rdy_dst;
  logic [M*CW-1:0] occ_dst;
  logic            err_sel;

  modport master (
    output vld_src, pld_src, sel_src, rdy_dst,
    input  rdy_src, vld_dst, pld_dst, occ_dst, err_sel
  );

  modport slave (
    input  vld_src, pld_src, sel_src, rdy_dst,
    output rdy_src, vld_dst, pld_dst, occ_dst, err_sel
  );
endinterface

// File: rtl/sync_fifo_vr.sv
// rtl/sync_fifo_vr.sv - small synchronous FIFO, registered storage, no bypass
module sync_fifo_vr
  import demux_1tom_buf_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  output logic                       full,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic [clog2(DEPTH+1)-1:0]  count
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rptr];

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage is never reset; the consumer masks the head while empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/demux_1tom_buf.sv
// rtl/demux_1tom_buf.sv - 1-to-M valid/ready demux with a FIFO per destination
module demux_1tom_buf
  import demux_1tom_buf_pkg::*;
#(
  parameter int M     = M_DEF,
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  demux_1tom_buf_if.slave   bus
);
  localparam int SW   = clog2(M);
  localparam int CW   = clog2(DEPTH + 1);
  localparam int NSEL = 1 << SW;

  logic [M-1:0]    w_full;
  logic [M-1:0]    w_empty;
  logic [M-1:0]    w_push;
  logic [M-1:0]    w_pop;
  logic [NSEL-1:0] w_full_ext;
  logic [W-1:0]    w_dout  [M];
  logic [CW-1:0]   w_count [M];
  logic            w_sel_ok;
  logic            w_src_xfer;
  logic            r_err;

  assign w_sel_ok = (int'(bus.sel_src) < M);

  // Unused select codes read as not-full so they are always accepted
  always_comb begin
    w_full_ext         = '0;
    w_full_ext[M-1:0]  = w_full;
  end

  assign bus.rdy_src = w_sel_ok ? !w_full_ext[bus.sel_src] : 1'b1;
  assign w_src_xfer  = bus.vld_src && bus.rdy_src;

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= bus.vld_src && !w_sel_ok;
  end

  assign bus.err_sel = r_err;

  for (genvar g = 0; g < M; g++) begin : g_dst
    assign w_push[g] = w_src_xfer && w_sel_ok && (bus.sel_src == SW'(g));
    assign w_pop[g]  = bus.rdy_dst[g] && !w_empty[g];

    sync_fifo_vr #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push[g]),
      .din   (bus.pld_src),
      .full  (w_full[g]),
      .pop   (w_pop[g]),
      .dout  (w_dout[g]),
      .empty (w_empty[g]),
      .count (w_count[g])
    );

    assign bus.vld_dst[g]                       = !w_empty[g];
    assign bus.pld_dst[slice_lo(g, W) +: W]     = w_empty[g] ? '0 : w_dout[g];
    assign bus.occ_dst[slice_lo(g, CW) +: CW]   = w_count[g];
  end
endmodule

// File: tb/tb_demux_1tom_buf.sv
// tb/tb_demux_1tom_buf.sv - bench for demux_1tom_buf with a queue-based reference model
module tb_demux_1tom_buf;
  logic clk;
  logic rst;

  demux_1tom_buf_if #(.M(4), .W(8), .DEPTH(2)) bus4 ();
  demux_1tom_buf_if #(.M(3), .W(8), .DEPTH(2)) bus3 ();

  demux_1tom_buf #(.M(4), .W(8), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  demux_1tom_buf #(.M(3), .W(8), .DEPTH(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int deliv [4];
  logic [7:0] mq [4][$];
  bit last_xfer = 1'b0;
  bit exp_err   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare DUT against the queues, then advance the queues
  task automatic tick();
    logic [3:0]  ev;
    logic [31:0] ep;
    logic [7:0]  eo;
    bit          er;
    bit          x;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ev[i]        = (mq[i].size() != 0);
      ep[i*8 +: 8] = ev[i] ? mq[i][0] : 8'h00;
      eo[i*2 +: 2] = 2'(mq[i].size());
    end
    er = (mq[bus4.sel_src].size() < 2);
    chk("rdy_src", bus4.rdy_src, er);
    chk("vld_dst", bus4.vld_dst, ev);
    chk("pld_dst", bus4.pld_dst, ep);
    chk("occ_dst", bus4.occ_dst, eo);
    chk("err_sel", bus4.err_sel, exp_err);
    x = bus4.vld_src && er;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      last_xfer = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ev[i] && bus4.rdy_dst[i]) begin
          void'(mq[i].pop_front());
          deliv[i]++;
        end
      end
      if (x) mq[bus4.sel_src].push_back(bus4.pld_src);
      last_xfer = x;
    end
    exp_err = 1'b0;
    cyc++;
    #1;
  endtask

  task automatic send(input int s, input logic [7:0] p);
    bit ok;
    bus4.vld_src = 1'b1;
    bus4.sel_src = 2'(s);
    bus4.pld_src = p;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      ok = last_xfer;
    end
    bus4.vld_src = 1'b0;
    chk("send_done", ok, 1'b1);
  endtask

  // Source must hold valid and payload until it is accepted
  bit         p_pend = 1'b0;
  logic [1:0] p_sel;
  logic [7:0] p_pld;
  always @(posedge clk) begin
    if (p_pend) begin
      assert (bus4.vld_src === 1'b1 && bus4.sel_src === p_sel && bus4.pld_src === p_pld) else begin
        failures++;
        $error("FAIL src_protocol observed=%0b/%0h/%0h expected=1/%0h/%0h",
               bus4.vld_src, bus4.sel_src, bus4.pld_src, p_sel, p_pld);
      end
    end
    p_pend = !rst && bus4.vld_src && !bus4.rdy_src;
    p_sel  = bus4.sel_src;
    p_pld  = bus4.pld_src;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1;
    bus4.vld_src = 1'b0; bus4.sel_src = '0; bus4.pld_src = '0; bus4.rdy_dst = 4'hF;
    bus3.vld_src = 1'b0; bus3.sel_src = '0; bus3.pld_src = '0; bus3.rdy_dst = 3'h7;
    for (int i = 0; i < 4; i++) deliv[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_vld", bus4.vld_dst, 4'h0);
    chk("reset_pld", bus4.pld_dst, 32'h0);
    chk("reset_occ", bus4.occ_dst, 8'h0);
    chk("reset_err", bus4.err_sel, 1'b0);
    chk("reset_rdy", bus4.rdy_src, 1'b1);

    // Single beat, one cycle latency
    bus4.vld_src = 1'b1; bus4.sel_src = 2'd2; bus4.pld_src = 8'hA5;
    tick();
    bus4.vld_src = 1'b0;
    chk("single_vld", bus4.vld_dst, 4'b0100);
    chk("single_pld", bus4.pld_dst, 32'h00A5_0000);
    tick();
    chk("single_occ", bus4.occ_dst, 8'h0);

    // Backpressure on dst1 while dst0 keeps flowing
    for (int i = 0; i < 4; i++) deliv[i] = 0;
    bus4.rdy_dst = 4'b1101;
    send(1, 8'h01);
    send(1, 8'h02);
    chk("bp_occ1", bus4.occ_dst[3:2], 2'd2);
    bus4.sel_src = 2'd1;
    #1;
    chk("bp_rdy_low", bus4.rdy_src, 1'b0);
    send(0, 8'h30);
    send(0, 8'h31);
    bus4.vld_src = 1'b1; bus4.sel_src = 2'd1; bus4.pld_src = 8'h03;
    repeat (3) begin
      tick();
      chk("bp_stall", last_xfer, 1'b0);
    end
    bus4.rdy_dst = 4'hF;
    send(1, 8'h03);
    send(1, 8'h04);
    send(1, 8'h05);
    send(1, 8'h06);
    repeat (4) tick();
    chk("bp_deliv1", deliv[1], 6);
    chk("bp_deliv0", deliv[0], 2);

    // Streaming round-robin at full rate
    for (int i = 0; i < 4; i++) deliv[i] = 0;
    c0 = cyc;
    for (int n = 0; n < 100; n++) send(n % 4, 8'(n));
    chk("stream_cycles", cyc - c0, 100);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) chk("stream_deliv", deliv[i], 25);

    // Push and pop in the same cycle at occupancy 1
    bus4.rdy_dst = 4'b1110;
    send(0, 8'h11);
    chk("pp_occ_before", bus4.occ_dst[1:0], 2'd1);
    bus4.vld_src = 1'b1; bus4.sel_src = 2'd0; bus4.pld_src = 8'h22; bus4.rdy_dst = 4'hF;
    tick();
    bus4.vld_src = 1'b0;
    chk("pp_occ_after", bus4.occ_dst[1:0], 2'd1);
    chk("pp_head", bus4.pld_dst[7:0], 8'h22);
    tick();

    // Mid-stream reset with occupancies 2,1,0,2
    bus4.rdy_dst = 4'h0;
    send(0, 8'h40); send(0, 8'h41); send(1, 8'h42); send(3, 8'h43); send(3, 8'h44);
    chk("mid_occ", bus4.occ_dst, 8'h86);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_vld", bus4.vld_dst, 4'h0);
    chk("mid_pld", bus4.pld_dst, 32'h0);
    chk("mid_occ0", bus4.occ_dst, 8'h0);
    for (int s = 0; s < 4; s++) begin
      bus4.sel_src = 2'(s);
      #1;
      chk("mid_rdy", bus4.rdy_src, 1'b1);
    end

    // Randomised traffic against the queue model
    for (int n = 0; n < 300; n++) begin
      if (!(bus4.vld_src && !last_xfer)) begin
        bus4.vld_src = 1'($urandom_range(0, 1));
        bus4.sel_src = 2'($urandom_range(0, 3));
        bus4.pld_src = 8'($urandom);
      end
      bus4.rdy_dst = 4'($urandom);
      tick();
    end
    bus4.vld_src = 1'b0;
    bus4.rdy_dst = 4'hF;
    repeat (4) tick();
    chk("rand_drain", bus4.occ_dst, 8'h0);

    // Out-of-range select on the M=3 instance
    bus3.vld_src = 1'b1; bus3.sel_src = 2'd3; bus3.pld_src = 8'h77;
    #1;
    chk("oor_rdy", bus3.rdy_src, 1'b1);
    tick();
    bus3.vld_src = 1'b0;
    chk("oor_err", bus3.err_sel, 1'b1);
    chk("oor_vld", bus3.vld_dst, 3'b000);
    chk("oor_occ", bus3.occ_dst, 6'h0);
    tick();
    chk("oor_err_clear", bus3.err_sel, 1'b0);
    bus3.vld_src = 1'b1; bus3.sel_src = 2'd2; bus3.pld_src = 8'h5A;
    tick();
    bus3.vld_src = 1'b0;
    chk("m3_vld", bus3.vld_dst, 3'b100);
    chk("m3_pld", bus3.pld_dst, 24'h5A_0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
